// File: rtl/port_display_scan_if.sv
// port_display_scan_if: output-port bytes and blank requests in, multiplexed display pins out.
interface port_display_scan_if;
    logic [7:0] d0_s;
    logic [7:0] d1_s;
    logic [7:0] d2_s;
    logic [7:0] d3_s;
    logic [3:0] blank;
    logic [6:0] seg;
    logic [7:0] an;
    logic       frame;
    modport master (output d0_s, d1_s, d2_s, d3_s, blank, input seg, an, frame);
    modport slave  (input d0_s, d1_s, d2_s, d3_s, blank, output seg, an, frame);
endinterface

// File: rtl/port_display_scan.sv
// port_display_scan: scans four snapshotted port bytes onto an 8-digit hex 7-segment display.
module port_display_scan #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int CNT_W          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    port_display_scan_if.slave  bus
);
    if (REFRESH_CYCLES < 2 || longint'(REFRESH_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_refresh
        $error("port_display_scan: REFRESH_CYCLES=%0d outside 2..2**CNT_W (CNT_W=%0d)", REFRESH_CYCLES, CNT_W);
    end
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [6:0]       SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [7:0]       AN_INV  = {8{AN_ACTIVE_LOW}};
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       snap [4];
    logic [3:0]       snap_blank;
    logic             tick;
    logic             wrap;
    logic             off;
    logic [3:0]       nib;
    logic [6:0]       glyph;
    logic [7:0]       sel;
    always_comb begin
        tick  = cnt == LAST;
        wrap  = tick && idx == 3'd7;
        off   = snap_blank[idx[2:1]];
        nib   = idx[0] ? snap[idx[2:1]][7:4] : snap[idx[2:1]][3:0];
        sel   = off ? 8'h00 : 8'h01 << idx;
        glyph = 7'h00;
        case (nib)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            4'hF: glyph = 7'b1110001;
        endcase
    end
    // Snapshot lands on the same edge idx wraps, so a whole frame shows one consistent set of bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '{default: '0};
            snap_blank <= '0;
            bus.frame  <= 1'b0;
            bus.seg    <= SEG_INV;
            bus.an     <= AN_INV;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            idx       <= tick ? idx + 1'b1 : idx;
            bus.frame <= wrap;
            if (wrap) begin
                snap[0]    <= bus.d0_s;
                snap[1]    <= bus.d1_s;
                snap[2]    <= bus.d2_s;
                snap[3]    <= bus.d3_s;
                snap_blank <= bus.blank;
            end
            bus.seg <= (off ? 7'h00 : glyph) ^ SEG_INV;
            bus.an  <= sel ^ AN_INV;
        end
    end
endmodule

// File: doc/port_display_scan.md
Name: port_display_scan

Overview:
- Output-side peripheral that consumes the microcontroller's four registered 8-bit output ports and drives an 8-digit multiplexed 7-segment display.
- Each port byte is shown as two hex digits.
- Each scan frame displays an atomic snapshot of all ports, so a program rewriting ports mid-frame never produces torn digits.
- Sits directly downstream of the microcontroller's output port registers, between them and the board pins.

Parameters:
- REFRESH_CYCLES, 50000, clk cycles each digit stays lit; legal range 2..2^CNT_W.
- CNT_W, 16, width of the prescaler counter.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (0 lights a segment).
- AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (0 enables a digit).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- d0_s  in  8  output port 0 value.
- d1_s  in  8  output port 1 value.
- d2_s  in  8  output port 2 value.
- d3_s  in  8  output port 3 value.
- blank  in  4  per-port blank request; bit k blanks both digits of port k.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- an  out  8  digit enables; an[i] selects digit i.
- frame  out  1  one-cycle pulse on each snapshot/frame start.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-scan. All state clears:
  - cnt=0, idx=0, snap0..3=0, snap_blank=4'b0000, frame=0.
  - an = all digits disabled; seg = all segments off (polarity per parameters).
- Prescaler:
  - cnt increments every clk.
  - tick = (cnt==REFRESH_CYCLES-1); on tick, cnt returns to 0.
- Digit index:
  - idx is 3 bits and advances on tick, wrapping 7->0.
  - One frame = 8*REFRESH_CYCLES cycles.
- Snapshot:
  - Trigger is the cycle where tick && idx==7.
  - On that cycle, snap_k <= d{k}_s and snap_blank <= blank, in the same edge as idx wraps to 0.
  - frame is registered high for exactly that following cycle.
  - Port changes at any other time have no visible effect until the next snapshot.
- Until the first snapshot, snap=0, so all 8 digits show "0".
- Digit mapping:
  - idx 2k shows snap_k[3:0] (low nibble); idx 2k+1 shows snap_k[7:4] (high nibble).
  - Digit 0 is the rightmost digit.
- Outputs:
  - seg and an are registered from idx, snap and snap_blank, giving 1-cycle latency after idx changes.
  - Exactly one an bit is active, except that a digit whose port is blanked has an fully inactive and seg all off for its time slot.
- Hex font, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Polarity: SEG_ACTIVE_LOW / AN_ACTIVE_LOW invert the final outputs only. Internal logic is always active-high.
- Width rules: cnt compare is done at CNT_W bits. REFRESH_CYCLES > 2^CNT_W is illegal; the implementation must check it in simulation (elaboration-time error).
- Simultaneous events: reset dominates tick and snapshot. Port changes in the snapshot cycle are captured with their value at that edge.

Test Plan:
1. REFRESH_CYCLES=4, defaults; assert reset mid-scan (idx=5) -> same cycle an=8'hFF, seg=7'h7F, frame=0. After release, the first tick occurs 4 cycles later.
2. d0_s=8'h3A held; run past the first frame pulse (cycle 32) -> digit 0 slot: an=8'hFE, seg=~1110111=7'b0001000 ("A"). Digit 1 slot: an=8'hFD, seg=~1001111=7'b0110000 ("3").
3. d2_s=8'h11 at snapshot; change to 8'hFF during idx=2 -> digits 4/5 keep showing "1" until the next frame pulse, then show "F".
4. blank=4'b0010 -> during idx 2 and 3, an=8'hFF and seg=7'h7F. All other slots unaffected. Deasserting blank takes effect only after the next frame pulse.
5. Free-run 10 frames -> frame pulses exactly every 32 cycles, one cycle wide. idx sequence 0..7 repeats; never two an bits active.
6. Sweep d0_s..d3_s through 0x10,0x32,0x54,...,0xFE across frames -> all 16 nibble values appear on seg matching the font table, in both polarities (rerun with SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0).
